fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
- Pointer and flag controller for the Cola_fifo queue. Sits directly upstream of the FIFO's dual-port register bank.
- Turns user push/pop requests into the bank's write enable, write address and read address.
- Keeps registered full and empty flags so the bank is never overwritten or over-read.
- Read data is taken combinationally from the bank at r_addr; this block holds no data.

Parameters:
- A, 4, number of address bits; FIFO depth = 2**A entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; the word is on the bank's data input this cycle.
- rd  input  1  pop request; consumes the word currently shown at r_addr.
- wr_en  output  1  write enable to the register bank (combinational).
- w_addr  output  A  write pointer; address of the next free slot.
- r_addr  output  A  read pointer; address of the oldest valid word.
- full  output  1  registered; asserted when 2**A words are held.
- empty  output  1  registered; asserted when 0 words are held.
- count  output  A+1  occupancy, 0..2**A (present only with FIFO_CTRL_COUNT_EN).

Behaviour:
- Reset (synchronous, rising clk with reset=1):
  - w_addr=0, r_addr=0, full=0, empty=1, count=0.
  - reset has priority over wr/rd in the same cycle.
  - Reset mid-operation discards all contents; bank data is not cleared, only the pointers.
- Accept rules, evaluated each cycle from the current registered flags:
  - push accepted (pa) = wr & (~full | rd)
  - pop accepted (pp) = rd & ~empty
- wr_en = pa. Purely combinational, same cycle as wr. Bank write latency is 1 clk.
- Next-state, one case per combination of pa and pp:
  - pa & ~pp: w_addr+1; empty<=0; full<=1 iff w_addr+1 == r_addr.
  - ~pa & pp: r_addr+1; full<=0; empty<=1 iff r_addr+1 == w_addr.
  - pa & pp: both pointers +1; full and empty unchanged.
  - neither: hold.
- Pointer arithmetic is modulo 2**A; wrap from 2**A-1 to 0 is natural A-bit overflow. No extra wrap bit is used.
- Boundary conditions:
  - Push when full with no pop: ignored, wr_en=0, no state change.
  - Pop when empty: ignored, r_addr holds. The read data is don't-care.
  - Push and pop while empty: only the push is accepted (pp=0). empty deasserts next cycle, r_addr holds.
  - Push and pop while full: both accepted. The old word at r_addr is consumed this cycle and the new word overwrites that slot at the edge; full stays 1.
- Flag invariant: full & empty is never 1.
- Latency: a word pushed in cycle N is visible at the bank's read output from cycle N+1, with empty=0 in cycle N+1.

Optional Feature:
- Macro: FIFO_CTRL_COUNT_EN.
- Defined:
  - count port exists and is a registered occupancy counter.
  - +1 on pa&~pp, -1 on ~pa&pp, held otherwise; reset to 0.
  - Flags must equal (count==2**A) and (count==0); the bench checks this.
- Undefined: no count port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package/header fifo_defs holds the default constants W=8 and A=4 for the whole Cola_fifo.
- No typedefs are needed; flag/pointer state is plain registers, no enumerated FSM.
- No sub-module inside fifo_ctrl.
- Top-level fifo (next block) instantiates fifo_ctrl plus the register bank:
  - wr_en to bank wr_en; w_addr to address_w; r_addr to address_r.

Test Plan (A=2, depth 4):
- Reset then idle -> empty=1, full=0, w_addr=0, r_addr=0, wr_en=0.
- Push 4 words (0x11..0x44), no pops -> full=1 after the 4th edge, w_addr=0. A 5th push gives wr_en=0 and no state change.
- From full, pop 4 words -> data out in order 0x11,0x22,0x33,0x44, empty=1 after the 4th edge, r_addr=0. A 5th pop leaves r_addr unchanged.
- Empty, assert wr=rd=1 with data 0xA5 -> only the write is taken. Next cycle empty=0, r_addr=0, read data=0xA5.
- Full, assert wr=rd=1 with 0x99 -> the oldest word is consumed, both pointers +1, full stays 1. 0x99 emerges 4 pops later.
- Push 2 words, then reset mid-stream while wr=1 -> next cycle empty=1, pointers 0, and count=0 if FIFO_CTRL_COUNT_EN.

Source files
------------

// File: rtl/fifo_defs.sv
// Shared default constants for the Cola_fifo: data width W and address bits A.
package fifo_defs;
  localparam int W = 8;
  localparam int A = 4;
endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the Cola_fifo register bank (depth 2**A).
// Define FIFO_CTRL_COUNT_EN to add the registered occupancy output 'count'.
module fifo_ctrl #(
  parameter int A = fifo_defs::A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [A-1:0] w_addr,
  output logic [A-1:0] r_addr,
  output logic         full,
`ifdef FIFO_CTRL_COUNT_EN
  output logic [A:0]   count,
`endif
  output logic         empty
);

  localparam logic [A-1:0] PTR_ONE = 1;

  logic         pa;
  logic         pp;
  logic [A-1:0] w_next;
  logic [A-1:0] r_next;

  // A pop in the same cycle frees the slot a full FIFO's push will reuse.
  assign pa     = wr & (~full | rd);
  assign pp     = rd & ~empty;
  assign wr_en  = pa;
  assign w_next = w_addr + PTR_ONE;
  assign r_next = r_addr + PTR_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr <= '0;
      r_addr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      case ({pa, pp})
        2'b10: begin
          w_addr <= w_next;
          empty  <= 1'b0;
          full   <= (w_next == r_addr);
        end
        2'b01: begin
          r_addr <= r_next;
          full   <= 1'b0;
          empty  <= (r_next == w_addr);
        end
        2'b11: begin
          w_addr <= w_next;
          r_addr <= r_next;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_CTRL_COUNT_EN
  localparam logic [A:0] CNT_ONE = 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (pa & ~pp) begin
      count <= count + CNT_ONE;
    end else if (~pa & pp) begin
      count <= count - CNT_ONE;
    end
  end
`endif

endmodule
